// File: rtl/decodificador_segmentos_pkg.sv
// pacote_segmentos: constants shared with the encoder/display block.
//   SEG_*       : segment patterns {a,b,c,d,e,f,g} for each 2-bit code and blank
//   dec_t       : result of decodifica() {valido, apagado, code}
//   estado_t    : output register state (VAZIO = empty, CHEIO = holding a code)
package pacote_segmentos;

  localparam logic [6:0] SEG_00      = 7'b0001100;
  localparam logic [6:0] SEG_01      = 7'b1111010;
  localparam logic [6:0] SEG_10      = 7'b1111100;
  localparam logic [6:0] SEG_11      = 7'b1110011;
  localparam logic [6:0] SEG_APAGADO = 7'b0000000;

  typedef struct packed {
    logic       valido;
    logic       apagado;
    logic [1:0] code;
  } dec_t;

  typedef enum logic {VAZIO = 1'b0, CHEIO = 1'b1} estado_t;

  function automatic dec_t decodifica(input logic [6:0] seg);
    dec_t r;
    r = '0;
    case (seg)
      SEG_00:      begin r.valido = 1'b1; r.code = 2'b00; end
      SEG_01:      begin r.valido = 1'b1; r.code = 2'b01; end
      SEG_10:      begin r.valido = 1'b1; r.code = 2'b10; end
      SEG_11:      begin r.valido = 1'b1; r.code = 2'b11; end
      SEG_APAGADO: r.apagado = 1'b1;
      default:     r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/decodificador_segmentos_if.sv
// Output side of the segment decoder: code, valid/ready handshake and flags.
//   master : driven by the decoder (y1, y0, y_valid, erro, sobrecarga), samples y_ready
//   slave  : consumer view, drives y_ready
interface decodificador_segmentos_if;
  logic y1;
  logic y0;
  logic y_valid;
  logic y_ready;
  logic erro;
  logic sobrecarga;

  modport master (output y1, y0, y_valid, erro, sobrecarga, input y_ready);
  modport slave  (input y1, y0, y_valid, erro, sobrecarga, output y_ready);
endinterface

// File: rtl/decodificador_segmentos_sincronizador.sv
// sincronizador: W-bit two-flop synchroniser for asynchronous inputs.
//   clk, rst : clock, async active-high reset (clears both stages)
//   d        : asynchronous input bits
//   q        : synchronised output (second stage)
module sincronizador #(
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] s1_q, s2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= d;
      s2_q <= s1_q;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/decodificador_segmentos.sv
// decodificador_segmentos: reader side of the 7-segment status link.
//   clk, rst      : clock, async active-high reset
//   seg_a..seg_g  : asynchronous segment lines, vector {a..g} = [6:0]
//   y (master)    : decoded code {y1,y0} with y_valid/y_ready handshake,
//                   erro (one-cycle invalid-pattern pulse), sobrecarga (sticky drop flag)
// Segments are synchronised, debounced for STABLE_CYCLES samples, decoded once per
// stable pattern and held in a one-entry output register.
module decodificador_segmentos
  import pacote_segmentos::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic seg_a,
  input  logic seg_b,
  input  logic seg_c,
  input  logic seg_d,
  input  logic seg_e,
  input  logic seg_f,
  input  logic seg_g,
  decodificador_segmentos_if.master y
);

  logic [6:0] seg_s;

  sincronizador #(.W(7)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   ({seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g}),
    .q   (seg_s)
  );

  // ---------------- debounce ----------------
  logic [6:0]       pat_d, pat_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             aceito;
  dec_t             dec;

  always_comb begin
    pat_d = pat_q;
    cnt_d = cnt_q;
    if (seg_s != pat_q) begin
      pat_d = seg_s;
      cnt_d = '0;
    end else if (cnt_q < CNT_W'(STABLE_CYCLES)) begin
      // saturating at STABLE_CYCLES keeps aceito from re-firing on a held pattern
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign aceito = (seg_s == pat_q) && (cnt_q == CNT_W'(STABLE_CYCLES - 1));
  assign dec    = decodifica(pat_q);

  // ---------------- output register FSM ----------------
  estado_t    estado_d, estado_q;
  logic [1:0] code_d, code_q;
  logic       valid_d, valid_q;
  logic       erro_d, erro_q;
  logic       sobre_d, sobre_q;
  logic       carrega;

  assign carrega = aceito & dec.valido;

  always_comb begin
    estado_d = estado_q;
    code_d   = code_q;
    sobre_d  = sobre_q;
    erro_d   = aceito & ~dec.valido & ~dec.apagado;
    case (estado_q)
      VAZIO: begin
        if (carrega) begin
          code_d   = dec.code;
          estado_d = CHEIO;
        end
      end
      CHEIO: begin
        if (y.y_ready) begin
          // handshake frees the register; a same-cycle code refills it with no bubble
          if (carrega) code_d   = dec.code;
          else         estado_d = VAZIO;
        end else if (carrega) begin
          sobre_d = 1'b1;
        end
      end
      default: estado_d = VAZIO;
    endcase
    valid_d = (estado_d == CHEIO);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pat_q    <= SEG_APAGADO;
      cnt_q    <= '0;
      estado_q <= VAZIO;
      code_q   <= 2'b00;
      valid_q  <= 1'b0;
      erro_q   <= 1'b0;
      sobre_q  <= 1'b0;
    end else begin
      pat_q    <= pat_d;
      cnt_q    <= cnt_d;
      estado_q <= estado_d;
      code_q   <= code_d;
      valid_q  <= valid_d;
      erro_q   <= erro_d;
      sobre_q  <= sobre_d;
    end
  end

  assign y.y1         = code_q[1];
  assign y.y0         = code_q[0];
  assign y.y_valid    = valid_q;
  assign y.erro       = erro_q;
  assign y.sobrecarga = sobre_q;

endmodule

// File: tb/tb_decodificador_segmentos.sv
module tb_decodificador_segmentos;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] seg = 7'b0;
  int         checks = 0;
  int         errors = 0;
  int         nval, nerr, saw10;
  logic [1:0] lastcode;

  decodificador_segmentos_if yif ();

  decodificador_segmentos dut (
    .clk   (clk),
    .rst   (rst),
    .seg_a (seg[6]),
    .seg_b (seg[5]),
    .seg_c (seg[4]),
    .seg_d (seg[3]),
    .seg_e (seg[2]),
    .seg_f (seg[1]),
    .seg_g (seg[0]),
    .y     (yif)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    nval = 0; nerr = 0; saw10 = 0; lastcode = 2'b00;
  endtask

  task automatic tick_mon();
    tick();
    if (yif.y_valid === 1'b1) begin
      nval++;
      lastcode = {yif.y1, yif.y0};
      if ({yif.y1, yif.y0} === 2'b10) saw10++;
    end
    if (yif.erro === 1'b1) nerr++;
  endtask

  function automatic logic [7:0] outs();
    return {3'b0, yif.y_valid, yif.y1, yif.y0, yif.erro, yif.sobrecarga};
  endfunction

  initial begin
    yif.y_ready = 1'b1;
    // 1: reset with a valid code on the lines
    seg = 7'b1111010;
    rst = 1'b1;
    #1;
    chk("reset_async_outs", outs(), 8'h00);
    repeat (3) tick();
    chk("reset_held_outs", outs(), 8'h00);
    rst = 1'b0;
    clr();
    repeat (6) tick_mon();
    chk("rst_latency_early", 8'(nval), 8'd0);
    // 2: delivery lands exactly at E0+6
    tick();
    chk("basic_valid", {7'b0, yif.y_valid}, 8'd1);
    chk("basic_code", {6'b0, yif.y1, yif.y0}, 8'b01);
    chk("basic_erro", {7'b0, yif.erro}, 8'd0);
    clr();
    repeat (10) tick_mon();
    chk("basic_once", 8'(nval), 8'd0);

    // 3: short glitch of 10 followed by a stable 00
    clr();
    seg = 7'b1111100;
    repeat (3) tick_mon();
    seg = 7'b0001100;
    repeat (12) tick_mon();
    chk("glitch_nval", 8'(nval), 8'd1);
    chk("glitch_code", {6'b0, lastcode}, 8'b00);
    chk("glitch_no10", 8'(saw10), 8'd0);
    chk("glitch_erro", 8'(nerr), 8'd0);

    // 4: invalid pattern, then blank
    clr();
    seg = 7'b1010101;
    repeat (6) tick_mon();
    chk("inval_early", 8'(nerr), 8'd0);
    tick();
    chk("inval_erro", {7'b0, yif.erro}, 8'd1);
    chk("inval_novalid", {7'b0, yif.y_valid}, 8'd0);
    tick();
    chk("inval_pulse1", {7'b0, yif.erro}, 8'd0);
    clr();
    repeat (2) tick_mon();
    seg = 7'b0000000;
    repeat (10) tick_mon();
    chk("blank_erro", 8'(nerr), 8'd0);
    chk("blank_valid", 8'(nval), 8'd0);

    // 5: backpressure, second code dropped
    yif.y_ready = 1'b0;
    seg = 7'b1110011;
    repeat (8) tick();
    chk("bp_hold", {6'b0, yif.y_valid, yif.sobrecarga}, 8'b10);
    chk("bp_code", {6'b0, yif.y1, yif.y0}, 8'b11);
    seg = 7'b0000000;
    repeat (8) tick();
    seg = 7'b0001100;
    repeat (8) tick();
    chk("bp_keep", {5'b0, yif.y_valid, yif.y1, yif.y0}, 8'b111);
    chk("bp_sobre", {7'b0, yif.sobrecarga}, 8'd1);
    yif.y_ready = 1'b1;
    #1;
    chk("bp_pre_xfer", {7'b0, yif.y_valid}, 8'd1);
    tick();
    chk("bp_xfer", {7'b0, yif.y_valid}, 8'd0);
    chk("bp_sticky", {7'b0, yif.sobrecarga}, 8'd1);
    clr();
    repeat (3) tick_mon();
    chk("bp_drop", 8'(nval), 8'd0);

    // 6: back-to-back refill, then asynchronous reset
    yif.y_ready = 1'b0;
    seg = 7'b0000000;
    repeat (8) tick();
    seg = 7'b1110011;
    repeat (8) tick();
    chk("b2b_full", {5'b0, yif.y_valid, yif.y1, yif.y0}, 8'b111);
    seg = 7'b1111010;
    repeat (6) tick();
    chk("b2b_before", {5'b0, yif.y_valid, yif.y1, yif.y0}, 8'b111);
    yif.y_ready = 1'b1;
    tick();
    chk("b2b_after", {5'b0, yif.y_valid, yif.y1, yif.y0}, 8'b101);
    chk("b2b_sobre_pre", {7'b0, yif.sobrecarga}, 8'd1);
    yif.y_ready = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_outs", outs(), 8'h00);
    tick();
    rst = 1'b0;
    repeat (2) tick();
    chk("postrst_outs", outs(), 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
